// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues byte-lane-aligned load/store requests to the
// data cache, stalls upstream until each access completes, and feeds write-back.
module mem_access_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH_I,
  input  logic [1:0]            DATA_CACHE_CONTROL,
  input  logic [1:0]            TYPE_IN,
  input  logic                  LOAD_UNSIGNED,
  input  logic [ADDR_WIDTH-1:0] DATA_ADDRESS,
  input  logic [DATA_WIDTH-1:0] WB_DATA,
  input  logic [DATA_WIDTH-1:0] STORE_DATA,
  input  logic [4:0]            RD_IN,
  output logic                  DCACHE_REQ,
  output logic                  DCACHE_WE,
  output logic [ADDR_WIDTH-1:0] DCACHE_ADDR,
  output logic [3:0]            DCACHE_WSTRB,
  output logic [DATA_WIDTH-1:0] DCACHE_WDATA,
  input  logic                  DCACHE_READY,
  input  logic                  DCACHE_VALID,
  input  logic [DATA_WIDTH-1:0] DCACHE_RDATA,
  output logic                  STALL,
  output logic                  WB_VALID,
  output logic [DATA_WIDTH-1:0] WB_DATA_OUT,
  output logic [4:0]            RD_OUT,
  output logic                  MISALIGNED,
  output logic [ADDR_WIDTH-1:0] MISALIGNED_ADDR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                  wb_valid_q, wb_valid_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [4:0]            rd_out_q, rd_out_d;
  logic                  mis_q, mis_d;
  logic [ADDR_WIDTH-1:0] mis_addr_q, mis_addr_d;
  logic [1:0]            lane_q, lane_d;
  logic [1:0]            type_q, type_d;
  logic                  uns_q, uns_d;
  logic [4:0]            rd_q, rd_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  mem_op_s;
  logic                  misalign_s;
  logic                  aligned_op_s;
  logic [7:0]            rbyte_s;
  logic [15:0]           rhalf_s;
  logic [DATA_WIDTH-1:0] load_ext_s;

  assign mem_op_s     = !FLUSH_I && ((DATA_CACHE_CONTROL == 2'b01) || (DATA_CACHE_CONTROL == 2'b10));
  assign misalign_s   = ((TYPE_IN == 2'b01) && DATA_ADDRESS[0]) ||
                        (TYPE_IN[1] && (DATA_ADDRESS[1:0] != 2'b00));
  assign aligned_op_s = mem_op_s && !misalign_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = aligned_op_s ? S_REQ : S_IDLE;
      S_REQ:   state_d = DCACHE_READY ? (we_q ? S_IDLE : S_WAIT) : S_REQ;
      S_WAIT:  state_d = DCACHE_VALID ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: the request is a pure function of the state register, so reset drops it at once.
  always_comb begin
    DCACHE_REQ = 1'b0;
    STALL      = 1'b0;
    case (state_q)
      S_IDLE:  STALL = aligned_op_s;
      S_REQ: begin
        DCACHE_REQ = 1'b1;
        STALL      = !(we_q && DCACHE_READY);
      end
      S_WAIT:  STALL = !DCACHE_VALID;
      default: STALL = 1'b0;
    endcase
  end

  always_comb begin
    rbyte_s = DCACHE_RDATA[{lane_q, 3'b000} +: 8];
    rhalf_s = DCACHE_RDATA[{lane_q[1], 4'b0000} +: 16];
    case (type_q)
      2'b00:   load_ext_s = uns_q ? {24'd0, rbyte_s} : {{24{rbyte_s[7]}}, rbyte_s};
      2'b01:   load_ext_s = uns_q ? {16'd0, rhalf_s} : {{16{rhalf_s[15]}}, rhalf_s};
      default: load_ext_s = DCACHE_RDATA;
    endcase
  end

  always_comb begin
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    rd_out_d   = rd_out_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    lane_d     = lane_q;
    type_d     = type_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    we_d       = we_q;
    daddr_d    = daddr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (!mem_op_s) begin
          wb_data_d  = WB_DATA;
          rd_out_d   = RD_IN;
          wb_valid_d = !FLUSH_I && (RD_IN != 5'd0);
        end else if (misalign_s) begin
          mis_d      = 1'b1;
          mis_addr_d = DATA_ADDRESS;
        end else begin
          lane_d  = DATA_ADDRESS[1:0];
          type_d  = TYPE_IN;
          uns_d   = LOAD_UNSIGNED;
          rd_d    = RD_IN;
          we_d    = DATA_CACHE_CONTROL[1];
          daddr_d = {DATA_ADDRESS[ADDR_WIDTH-1:2], 2'b00};
          if (DATA_CACHE_CONTROL[1]) begin
            case (TYPE_IN)
              2'b00: begin
                wstrb_d = 4'b0001 << DATA_ADDRESS[1:0];
                wdata_d = {4{STORE_DATA[7:0]}};
              end
              2'b01: begin
                wstrb_d = 4'b0011 << DATA_ADDRESS[1:0];
                wdata_d = {2{STORE_DATA[15:0]}};
              end
              default: begin
                wstrb_d = 4'b1111;
                wdata_d = STORE_DATA;
              end
            endcase
          end else begin
            wstrb_d = 4'b0000;
            wdata_d = {DATA_WIDTH{1'b0}};
          end
        end
      end
      S_WAIT: begin
        if (DCACHE_VALID) begin
          wb_valid_d = 1'b1;
          wb_data_d  = load_ext_s;
          rd_out_d   = rd_q;
        end else begin
          wb_valid_d = 1'b0;
        end
      end
      default: wb_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= {DATA_WIDTH{1'b0}};
      rd_out_q   <= 5'd0;
      mis_q      <= 1'b0;
      mis_addr_q <= {ADDR_WIDTH{1'b0}};
      lane_q     <= 2'b00;
      type_q     <= 2'b00;
      uns_q      <= 1'b0;
      rd_q       <= 5'd0;
      we_q       <= 1'b0;
      daddr_q    <= {ADDR_WIDTH{1'b0}};
      wstrb_q    <= 4'b0000;
      wdata_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      rd_out_q   <= rd_out_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
      lane_q     <= lane_d;
      type_q     <= type_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      daddr_q    <= daddr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
    end
  end

  assign DCACHE_WE       = we_q;
  assign DCACHE_ADDR     = daddr_q;
  assign DCACHE_WSTRB    = wstrb_q;
  assign DCACHE_WDATA    = wdata_q;
  assign WB_VALID        = wb_valid_q;
  assign WB_DATA_OUT     = wb_data_q;
  assign RD_OUT          = rd_out_q;
  assign MISALIGNED      = mis_q;
  assign MISALIGNED_ADDR = mis_addr_q;

endmodule
